alu_issue: RTL

- Producer side of the ALU decoder interface.
- Accepts operation requests over a valid/ready handshake, encodes each one into the 16-bit IR word, and drives IR plus operands A/B to my_decoder/my_ALU.
- Waits a programmable settle time, captures R, and returns the result over a valid/ready response channel.
- Sits between the control sequencer and the combinational decoder/ALU pair.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_ir_encoder.sv | 22 ++
 rtl/alu_issue.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Encoding shared by the issue block and my_decoder: op codes, FUNC nibbles,
// IR field positions and the NOP word.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5
  } alu_op_e;

  localparam logic [3:0] FUNC_ADD = 4'b1010;
  localparam logic [3:0] FUNC_SUB = 4'b0010;
  localparam logic [3:0] FUNC_AND = 4'b1100;
  localparam logic [3:0] FUNC_OR  = 4'b0110;
  localparam logic [3:0] FUNC_XOR = 4'b1110;
  localparam logic [3:0] FUNC_NOT = 4'b0100;

  localparam int IR_CLASS_LSB = 12;
  localparam int IR_RD_LSB    = 8;
  localparam int IR_FUNC_LSB  = 4;
  localparam int IR_RS_LSB    = 0;

  localparam logic [3:0]        ALU_CLASS = 4'b0000;
  localparam logic [DATA_W-1:0] NOP_WORD  = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

  function automatic logic [3:0] func_code(input alu_op_e op);
    logic [3:0] f;
    case (op)
      OP_ADD:  f = FUNC_ADD;
      OP_SUB:  f = FUNC_SUB;
      OP_AND:  f = FUNC_AND;
      OP_OR:   f = FUNC_OR;
      OP_XOR:  f = FUNC_XOR;
      OP_NOT:  f = FUNC_NOT;
      default: f = 4'b1111;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request, decoder/ALU and response signals of the ALU issue block.
// master = sequencer plus decoder/ALU side, slave = alu_issue.
interface alu_issue_if;
  import alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [3:0]        req_rd;
  logic [3:0]        req_rs;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [DATA_W-1:0] ir_out;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              is_alu_in;
  logic [DATA_W-1:0] alu_r;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_r;
  logic              rsp_err;
  logic [15:0]       issue_cnt;

  modport master (
    output req_valid, req_op, req_rd, req_rs, req_a, req_b,
    output is_alu_in, alu_r, rsp_ready,
    input  req_ready, ir_out, a_out, b_out, rsp_valid, rsp_r, rsp_err, issue_cnt
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs, req_a, req_b,
    input  is_alu_in, alu_r, rsp_ready,
    output req_ready, ir_out, a_out, b_out, rsp_valid, rsp_r, rsp_err, issue_cnt
  );

endinterface

// File: rtl/alu_ir_encoder.sv
// Combinational map from op/rd/rs to the 16-bit IR word, plus a legal flag
// (ops 6 and 7 have no FUNC code).
module alu_ir_encoder
  import alu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  output logic [DATA_W-1:0] ir,
  output logic              legal
);

  always_comb begin
    legal = (op <= 3'd5);
    ir = '0;
    ir[IR_CLASS_LSB +: 4] = ALU_CLASS;
    ir[IR_RD_LSB +: 4]    = rd;
    ir[IR_FUNC_LSB +: 4]  = func_code(alu_op_e'(op));
    ir[IR_RS_LSB +: 4]    = rs;
  end

endmodule

// File: rtl/alu_issue.sv
// Issues one ALU operation at a time to the decoder/ALU pair, waits
// SETTLE_CYCLES for the combinational path, then returns R over rsp_*.
module alu_issue
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int W             = 16
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  issue_state_e   state_reg, state_next;
  logic [W-1:0]   ir_reg, ir_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [W-1:0]   rsp_r_reg, rsp_r_next;
  logic           rsp_err_reg, rsp_err_next;
  logic [15:0]    issue_cnt_reg, issue_cnt_next;

  logic [W-1:0]   enc_ir;
  logic           enc_legal;

  alu_ir_encoder u_enc (
    .op    (bus.req_op),
    .rd    (bus.req_rd),
    .rs    (bus.req_rs),
    .ir    (enc_ir),
    .legal (enc_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ir_reg        <= NOP_WORD;
      a_reg         <= '0;
      b_reg         <= '0;
      cnt_reg       <= '0;
      rsp_r_reg     <= '0;
      rsp_err_reg   <= 1'b0;
      issue_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ir_reg        <= ir_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      cnt_reg       <= cnt_next;
      rsp_r_reg     <= rsp_r_next;
      rsp_err_reg   <= rsp_err_next;
      issue_cnt_reg <= issue_cnt_next;
    end
  end

  // req_* are only looked at under req_valid in IDLE, so X there stays contained.
  always_comb begin
    state_next     = state_reg;
    ir_next        = ir_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    cnt_next       = cnt_reg;
    rsp_r_next     = rsp_r_reg;
    rsp_err_next   = rsp_err_reg;
    issue_cnt_next = issue_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (enc_legal) begin
            ir_next    = enc_ir;
            a_next     = bus.req_a;
            b_next     = bus.req_b;
            cnt_next   = CNT_LOAD;
            state_next = ST_WAIT;
          end else begin
            rsp_r_next   = '0;
            rsp_err_next = 1'b1;
            state_next   = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          rsp_r_next     = bus.alu_r;
          rsp_err_next   = ~bus.is_alu_in;
          issue_cnt_next = issue_cnt_reg + 16'd1;
          ir_next        = NOP_WORD;
          state_next     = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.ir_out    = ir_reg;
  assign bus.a_out     = a_reg;
  assign bus.b_out     = b_reg;
  assign bus.rsp_r     = rsp_r_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.issue_cnt = issue_cnt_reg;

endmodule
